// File: rtl/tinyalu_arb_pkg.sv
// rtl/tinyalu_arb_pkg.sv - opcodes, FSM encoding and default latencies for the tinyalu arbiter
package tinyalu_arb_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    localparam int LAT_SINGLE_DEF = 1;
    localparam int LAT_MUL_DEF    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic op_uses_alu(input logic [2:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/tinyalu_rr_arb.sv
// rtl/tinyalu_rr_arb.sv - combinational round-robin grant searching upward from rr_ptr
module tinyalu_rr_arb #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PW-1:0]      rr_ptr,
    output logic               grant_any,
    output logic [PW-1:0]      grant_idx
);

    // Scanning from the far end down lets the nearest candidate win the last write.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin sharing of one tinyalu; TINYALU_ARB_DONE_CHECK_EN flags missing alu_done
module tinyalu_arbiter
    import tinyalu_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LAT_SINGLE = LAT_SINGLE_DEF,
    parameter int LAT_MUL    = LAT_MUL_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_op,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result,
    output logic                 busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LAT_MUL + 2);

    arb_state_t    state, next_state;
    logic [PW-1:0] rr_ptr, gnt_q, grant_idx;
    logic          grant_any;
    logic [7:0]    a_q, b_q;
    logic [2:0]    op_q;
    logic [CW-1:0] cnt, lat;
    logic [15:0]   res_q;
    logic          err_q;
    logic          uses_alu, exec_last, done_err;

    tinyalu_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    // No-op/illegal ops take a zero-length EXEC pass with the ALU untouched,
    // which gives them their two-cycle accept-to-response latency.
    assign uses_alu  = op_uses_alu(op_q);
    assign lat       = (op_q == OP_MUL) ? CW'(LAT_MUL) : (uses_alu ? CW'(LAT_SINGLE) : '0);
    assign exec_last = (cnt == lat);

`ifdef TINYALU_ARB_DONE_CHECK_EN
    assign done_err = uses_alu && !alu_done;
`else
    logic unused_alu_done;
    assign unused_alu_done = alu_done;
    assign done_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_any) next_state = EXEC;
            EXEC:    if (exec_last) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            gnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt    <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    gnt_q <= grant_idx;
                    a_q   <= req_a[{grant_idx, 3'b000} +: 8];
                    b_q   <= req_b[int'(grant_idx) * 3 * 8 / 3 +: 8];
                    op_q  <= req_op[int'(grant_idx) * 3 +: 3];
                    cnt   <= '0;
                end
                EXEC: begin
                    cnt <= cnt + CW'(1);
                    if (exec_last) begin
                        res_q <= uses_alu ? alu_result : 16'h0000;
                        err_q <= (op_q > OP_MUL) || done_err;
                    end
                end
                RESP: rr_ptr <= (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + PW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_result = 16'h0000;
        rsp_err    = 1'b0;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_op     = 3'd0;
        alu_start  = 1'b0;
        case (state)
            IDLE: if (grant_any) req_ready[grant_idx] = 1'b1;
            EXEC: if (uses_alu) begin
                alu_a     = a_q;
                alu_b     = b_q;
                alu_op    = op_q;
                alu_start = (cnt < lat);
            end
            RESP: begin
                if (uses_alu) begin
                    alu_a  = a_q;
                    alu_b  = b_q;
                    alu_op = op_q;
                end
                rsp_valid[gnt_q] = 1'b1;
                rsp_result       = res_q;
                rsp_err          = err_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
